riscv_mc_ctrl: RTL

Multi-cycle successor to the single-cycle control path. It holds the PC, old-PC and instruction registers, and sequences each RV32I instruction through a state machine. It drives one shared instruction/data memory through a req/ready handshake and issues per-state control to the register file/ALU datapath. It sits between the unified memory port and reg_alu_top, replacing PC_top plus the combinational CU.

---
 rtl/riscv_mc_ctrl.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_mc_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_mc_ctrl
// Multi-cycle RV32I control path. Holds the PC, old-PC and instruction
// registers and steps each instruction through a small state machine. It
// drives one shared instruction/data memory over a req/ready handshake and
// issues per-state control to the register-file/ALU datapath.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-low reset
//   mem_rdata      memory read data (instruction taken from bits [31:0])
//   mem_ready      memory completes the current request this cycle
//   zero           ALU zero flag (branch decision)
//   imm_ext        sign-extended immediate, selected by imm_src
//   pc             next fetch address
//   old_pc         address of the instruction in flight
//   instr          instruction register
//   mem_req        memory request
//   mem_we         memory write, qualified by mem_req
//   mem_addr_src   memory address select: 0 = pc, 1 = ALU result
//   reg_write      register file write enable
//   result_src     writeback select: 00 ALU, 01 mem, 10 pc (link), 11 imm
//   alu_src        ALU B select: 0 = rs2, 1 = imm_ext
//   alu_control    000 add, 001 sub, 010 and, 011 or, 101 slt
//   imm_src        000 I, 001 S, 010 B, 011 J, 100 U
//   instr_retired  pulse on the last cycle of an instruction
//   illegal_instr  pulse when an unsupported opcode is decoded
//   state          current state encoding, for debug
// -----------------------------------------------------------------------------
module riscv_mc_ctrl #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = {ADDRESS_WIDTH{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ready,
  input  logic                     zero,
  input  logic [DATA_WIDTH-1:0]    imm_ext,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [ADDRESS_WIDTH-1:0] old_pc,
  output logic [31:0]              instr,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     mem_addr_src,
  output logic                     reg_write,
  output logic [1:0]               result_src,
  output logic                     alu_src,
  output logic [2:0]               alu_control,
  output logic [2:0]               imm_src,
  output logic                     instr_retired,
  output logic                     illegal_instr,
  output logic [3:0]               state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP   = {{(ADDRESS_WIDTH-3){1'b0}}, 3'b100};
  localparam logic [31:0]              NOP_INSTR = 32'h0000_0013;

  // Decode target state for the instruction in the IR; S_FETCH marks illegal.
  function automatic state_t decode_next(input logic [6:0] opcode, input logic [2:0] funct3);
    state_t nxt;
    case (opcode)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_R:         nxt = S_EXEC_R;
      OP_I:         nxt = S_EXEC_I;
      OP_BRANCH:    nxt = (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_FETCH;
      OP_JAL:       nxt = S_JAL;
      OP_LUI:       nxt = S_LUI;
      default:      nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  // ALU operation from funct3; funct7[5] selects sub only for register ops.
  function automatic logic [2:0] alu_map(input logic [2:0] funct3, input logic sub_bit);
    logic [2:0] op;
    case (funct3)
      3'b000:  op = sub_bit ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      3'b010:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  state_t                     state_r;
  logic [ADDRESS_WIDTH-1:0]   pc_r;
  logic [ADDRESS_WIDTH-1:0]   old_pc_r;
  logic [31:0]                instr_r;

  logic [6:0]                 opcode_s;
  logic [2:0]                 funct3_s;
  logic                       funct7_5_s;
  logic                       branch_taken_s;
  logic [ADDRESS_WIDTH-1:0]   target_s;

  logic                       mem_req_s;
  logic                       mem_we_s;
  logic                       mem_addr_src_s;
  logic                       reg_write_s;
  logic [1:0]                 result_src_s;
  logic                       alu_src_s;
  logic [2:0]                 alu_control_s;
  logic [2:0]                 imm_src_s;
  logic                       instr_retired_s;
  logic                       illegal_instr_s;

  assign opcode_s   = instr_r[6:0];
  assign funct3_s   = instr_r[14:12];
  assign funct7_5_s = instr_r[30];

  // beq takes on zero, bne on not-zero; other funct3 never reach S_BRANCH.
  assign branch_taken_s = (funct3_s == 3'b000) ? zero : ~zero;
  assign target_s       = old_pc_r + imm_ext[ADDRESS_WIDTH-1:0];

  // State sequencing and the PC / old-PC / instruction registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= S_FETCH;
      pc_r     <= RESET_PC;
      old_pc_r <= {ADDRESS_WIDTH{1'b0}};
      instr_r  <= NOP_INSTR;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (mem_ready) begin
            instr_r  <= mem_rdata[31:0];
            old_pc_r <= pc_r;
            pc_r     <= pc_r + PC_STEP;
            state_r  <= S_DECODE;
          end else begin
            state_r  <= S_FETCH;
          end
        end
        S_DECODE:   state_r <= decode_next(opcode_s, funct3_s);
        S_MEMADR:   state_r <= (opcode_s == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  state_r <= mem_ready ? S_MEMWB : S_MEMREAD;
        S_MEMWB:    state_r <= S_FETCH;
        S_MEMWRITE: state_r <= mem_ready ? S_FETCH : S_MEMWRITE;
        S_EXEC_R:   state_r <= S_ALUWB;
        S_EXEC_I:   state_r <= S_ALUWB;
        S_ALUWB:    state_r <= S_FETCH;
        S_BRANCH: begin
          if (branch_taken_s) begin
            pc_r <= target_s;
          end else begin
            pc_r <= pc_r;
          end
          state_r <= S_FETCH;
        end
        S_JAL: begin
          pc_r    <= target_s;
          state_r <= S_FETCH;
        end
        S_LUI:      state_r <= S_FETCH;
        default:    state_r <= S_FETCH;
      endcase
    end
  end

  // Per-state control decode; anything a state does not drive stays 0.
  always_comb begin
    mem_req_s       = 1'b0;
    mem_we_s        = 1'b0;
    mem_addr_src_s  = 1'b0;
    reg_write_s     = 1'b0;
    result_src_s    = 2'b00;
    alu_src_s       = 1'b0;
    alu_control_s   = ALU_ADD;
    imm_src_s       = IMM_I;
    instr_retired_s = 1'b0;
    illegal_instr_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s = 1'b1;
      end
      S_DECODE: begin
        illegal_instr_s = (decode_next(opcode_s, funct3_s) == S_FETCH);
        instr_retired_s = illegal_instr_s;
      end
      S_MEMADR: begin
        alu_src_s = 1'b1;
        imm_src_s = (opcode_s == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_req_s      = 1'b1;
        mem_addr_src_s = 1'b1;
      end
      S_MEMWB: begin
        reg_write_s     = 1'b1;
        result_src_s    = 2'b01;
        instr_retired_s = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_s       = 1'b1;
        mem_we_s        = 1'b1;
        mem_addr_src_s  = 1'b1;
        instr_retired_s = mem_ready;
      end
      S_EXEC_R: begin
        alu_control_s = alu_map(funct3_s, funct7_5_s);
      end
      S_EXEC_I: begin
        alu_src_s     = 1'b1;
        alu_control_s = alu_map(funct3_s, 1'b0);
      end
      S_ALUWB: begin
        reg_write_s     = 1'b1;
        instr_retired_s = 1'b1;
      end
      S_BRANCH: begin
        alu_control_s   = ALU_SUB;
        imm_src_s       = IMM_B;
        instr_retired_s = 1'b1;
      end
      S_JAL: begin
        imm_src_s       = IMM_J;
        reg_write_s     = 1'b1;
        result_src_s    = 2'b10;
        instr_retired_s = 1'b1;
      end
      S_LUI: begin
        imm_src_s       = IMM_U;
        reg_write_s     = 1'b1;
        result_src_s    = 2'b11;
        instr_retired_s = 1'b1;
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // Holding rst low silences every control line, so an abandoned access
  // cannot leak a write while the block is being reset.
  assign mem_req       = rst & mem_req_s;
  assign mem_we        = rst & mem_we_s;
  assign mem_addr_src  = rst & mem_addr_src_s;
  assign reg_write     = rst & reg_write_s;
  assign result_src    = rst ? result_src_s  : 2'b00;
  assign alu_src       = rst & alu_src_s;
  assign alu_control   = rst ? alu_control_s : 3'b000;
  assign imm_src       = rst ? imm_src_s     : 3'b000;
  assign instr_retired = rst & instr_retired_s;
  assign illegal_instr = rst & illegal_instr_s;

  assign pc     = pc_r;
  assign old_pc = old_pc_r;
  assign instr  = instr_r;
  assign state  = state_r;

endmodule
